distribucion_salida_tm: RTL

DISTRIBUCION_SALIDA_TM -- requirements
Module: distribucion_salida_tm

---
 rtl/distribucion_salida_tm.sv | 128 ++++++++++++
 1 files changed

// File: rtl/distribucion_salida_tm.sv
// Output distribution stage: routes the switching signal either to the buck
// gate or to the two full-bridge diagonal pairs. Every mode change, and every
// release from reset, is followed by a dead-time guard interval. In
// full-bridge mode each pwm_in edge inserts a dead time before the opposite
// diagonal is turned on. All outputs come straight from flops.
module distribucion_salida_tm #(
   parameter int unsigned DT_CYC = 50
) (
   input  logic       CLK_100MHz,
   input  logic       reset,
   input  logic       pwm_in,
   input  logic       select_salida,
   output logic       BUCK_Gate,
   output logic       FB_QA,
   output logic       FB_QB,
   output logic [1:0] modo_activo,
   output logic       dt_activo
);

   typedef enum logic [1:0] {
      OFF  = 2'b00,
      BUCK = 2'b01,
      FB   = 2'b10
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(DT_CYC - 1);

   localparam logic [1:0] MODO_OFF  = 2'b00;
   localparam logic [1:0] MODO_BUCK = 2'b01;
   localparam logic [1:0] MODO_FB   = 2'b10;

   state_t     state;
   logic [7:0] cnt;
   logic       sel_prev;
   logic       pwm_prev;

   // Input history used for edge detection on the selector and pwm_in.
   always_ff @(posedge CLK_100MHz) begin
      sel_prev <= select_salida;
      pwm_prev <= pwm_in;
   end

   // Main FSM. The guard counter is shared by all states; in FB the
   // registered dt_activo doubles as the "waiting for dead time" flag.
   always_ff @(posedge CLK_100MHz) begin
      if (reset) begin
         state       <= OFF;
         cnt         <= 8'd0;
         BUCK_Gate   <= 1'b0;
         FB_QA       <= 1'b0;
         FB_QB       <= 1'b0;
         modo_activo <= MODO_OFF;
         dt_activo   <= 1'b1;
      end else if (state != OFF && select_salida != sel_prev) begin
         state       <= OFF;
         cnt         <= 8'd0;
         BUCK_Gate   <= 1'b0;
         FB_QA       <= 1'b0;
         FB_QB       <= 1'b0;
         modo_activo <= MODO_OFF;
         dt_activo   <= 1'b1;
      end else begin
         case (state)
            OFF: begin
               BUCK_Gate   <= 1'b0;
               FB_QA       <= 1'b0;
               FB_QB       <= 1'b0;
               modo_activo <= MODO_OFF;
               dt_activo   <= 1'b1;
               if (select_salida != sel_prev) begin
                  cnt <= 8'd0;
               end else if (cnt == CNT_LAST) begin
                  cnt       <= 8'd0;
                  dt_activo <= 1'b0;
                  if (select_salida) begin
                     state       <= FB;
                     modo_activo <= MODO_FB;
                     FB_QA       <= pwm_in;
                     FB_QB       <= ~pwm_in;
                  end else begin
                     state       <= BUCK;
                     modo_activo <= MODO_BUCK;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            BUCK: begin
               BUCK_Gate   <= pwm_in;
               FB_QA       <= 1'b0;
               FB_QB       <= 1'b0;
               modo_activo <= MODO_BUCK;
               dt_activo   <= 1'b0;
            end
            FB: begin
               BUCK_Gate   <= 1'b0;
               modo_activo <= MODO_FB;
               if (pwm_in != pwm_prev) begin
                  cnt       <= 8'd0;
                  FB_QA     <= 1'b0;
                  FB_QB     <= 1'b0;
                  dt_activo <= 1'b1;
               end else if (dt_activo) begin
                  if (cnt == CNT_LAST) begin
                     FB_QA     <= pwm_in;
                     FB_QB     <= ~pwm_in;
                     dt_activo <= 1'b0;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end else if (cnt != CNT_LAST) begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state       <= OFF;
               cnt         <= 8'd0;
               BUCK_Gate   <= 1'b0;
               FB_QA       <= 1'b0;
               FB_QB       <= 1'b0;
               modo_activo <= MODO_OFF;
               dt_activo   <= 1'b1;
            end
         endcase
      end
   end

endmodule
